// File: rtl/barrett_mod_mult_pipe.sv
// rtl/barrett_mod_mult_pipe.sv - pipelined (a*b) mod q with Barrett reduction and valid/ready flow control
// Four stages plus an output register, all stalled together when the output is held.
module barrett_mod_mult_pipe #(
  parameter int unsigned     data_size              = 64,
  parameter longint unsigned prime_number           = 7681,
  parameter int unsigned     no_of_bits_of_prime_no = $clog2(prime_number),
  parameter longint unsigned factor_approximate_div =
    (longint'(1) << (2 * no_of_bits_of_prime_no)) / prime_number,
  parameter int unsigned     tag_width              = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [data_size-1:0] in_a,
  input  logic [data_size-1:0] in_b,
  input  logic [tag_width-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [data_size-1:0] out_data,
  output logic [tag_width-1:0] out_tag
);

  localparam int unsigned DW  = data_size;
  localparam int unsigned DW2 = 2 * data_size;
  localparam int unsigned K   = no_of_bits_of_prime_no;
  localparam logic [DW-1:0]  Q   = DW'(prime_number);
  localparam logic [DW2-1:0] MU2 = DW2'(factor_approximate_div);

  logic                 s1_valid_q, s2_valid_q, s3_valid_q, s4_valid_q, out_valid_q;
  logic [tag_width-1:0] s1_tag_q, s2_tag_q, s3_tag_q, s4_tag_q, out_tag_q;
  logic [DW2-1:0]       s1_x_q;
  logic [DW-1:0]        s2_x_q, s2_qbar_q, s3_r_q, s4_r_q, out_data_q;

  logic                 adv;
  logic [DW2-1:0]       x_d;
  logic [DW-1:0]        qbar_d, r_d, r1_d, res_d;

  // Global stall: nothing moves while a result waits on the consumer.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign x_d    = DW2'(in_a) * DW2'(in_b);
  assign qbar_d = DW'(((s1_x_q >> K) * MU2) >> K);
  // Estimate is at most two short of the true quotient, so r < 3q; width DW suffices.
  assign r_d    = s2_x_q - (s2_qbar_q * Q);
  assign r1_d   = (s3_r_q >= Q) ? (s3_r_q - Q) : s3_r_q;
  assign res_d  = (s4_r_q >= Q) ? (s4_r_q - Q) : s4_r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s4_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_tag_q    <= '0;
      s2_tag_q    <= '0;
      s3_tag_q    <= '0;
      s4_tag_q    <= '0;
      out_tag_q   <= '0;
      s1_x_q      <= '0;
      s2_x_q      <= '0;
      s2_qbar_q   <= '0;
      s3_r_q      <= '0;
      s4_r_q      <= '0;
      out_data_q  <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      s4_valid_q  <= s3_valid_q;
      out_valid_q <= s4_valid_q;
      s1_tag_q    <= in_tag;
      s2_tag_q    <= s1_tag_q;
      s3_tag_q    <= s2_tag_q;
      s4_tag_q    <= s3_tag_q;
      s1_x_q      <= x_d;
      s2_x_q      <= s1_x_q[DW-1:0];
      s2_qbar_q   <= qbar_d;
      s3_r_q      <= r_d;
      s4_r_q      <= r1_d;
      // Bubbles leave the last visible result in place rather than exposing garbage.
      if (s4_valid_q) begin
        out_data_q <= res_d;
        out_tag_q  <= s4_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_barrett_mod_mult_pipe.sv
// tb/tb_barrett_mod_mult_pipe.sv - directed and sweep bench for barrett_mod_mult_pipe
module tb_barrett_mod_mult_pipe;
  localparam int DW = 64;
  localparam int TW = 8;
  localparam longint unsigned QA = 7681;
  localparam longint unsigned QB = 12289;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_a, a_in_b, a_out_data;
  logic [TW-1:0] a_in_tag, a_out_tag;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_a, b_in_b, b_out_data;
  logic [TW-1:0] b_in_tag, b_out_tag;

  barrett_mod_mult_pipe #(.data_size(DW), .prime_number(QA), .tag_width(TW)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_a(a_in_a), .in_b(a_in_b), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag)
  );

  barrett_mod_mult_pipe #(.data_size(DW), .prime_number(QB), .tag_width(TW)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_b(b_in_b), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    longint unsigned data;
    logic [TW-1:0]   tag;
  } exp_t;
  exp_t sb[$];

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
    tests++; if (a_out_data !== '0) begin fails++; $display("FAIL reset_data: got %0d want 0", a_out_data); end
    tests++; if (a_out_tag !== '0) begin fails++; $display("FAIL reset_tag: got %0h want 0", a_out_tag); end
    tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid_b: got %b want 0", b_out_valid); end
    rst_n = 1'b1;
    #1;
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
  endtask

  task automatic test_basic();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_a = 64'd1234; a_in_b = 64'd5678; a_in_tag = 8'h11;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin
        tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_at4: got %b want 1", a_out_valid); end
        tests++; if (a_out_data !== 64'd1580) begin fails++; $display("FAIL basic_data: got %0d want 1580", a_out_data); end
        tests++; if (a_out_tag !== 8'h11) begin fails++; $display("FAIL basic_tag: got %0h want 11", a_out_tag); end
      end else begin
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL basic_idle_cycle%0d: got %b want 0", k, a_out_valid); end
      end
    end
  endtask

  task automatic test_corners();
    longint unsigned ca[4] = '{0, 1, 7680, 7680};
    longint unsigned cb[4] = '{7000, 7680, 7680, 2};
    longint unsigned ce[4] = '{0, 7680, 1, 7679};
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_a = ca[i]; a_in_b = cb[i]; a_in_tag = 8'h20 + 8'(i);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (j < 4) begin
        tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL corner_valid%0d: got %b want 1", j, a_out_valid); end
        tests++; if (a_out_data !== ce[j]) begin fails++; $display("FAIL corner_data%0d: got %0d want %0d", j, a_out_data, ce[j]); end
        tests++; if (a_out_tag !== 8'h20 + 8'(j)) begin fails++; $display("FAIL corner_tag%0d: got %0h want %0h", j, a_out_tag, 8'h20 + 8'(j)); end
      end else begin
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL corner_tail%0d: got %b want 0", j, a_out_valid); end
      end
    end
  endtask

  task automatic test_sweep();
    longint unsigned bset[64];
    int n_ops = 2 * int'(QA);
    int idx = 0;
    int rcv = 0;
    exp_t e;
    bset[0] = 0;
    bset[1] = QA - 1;
    for (int i = 2; i < 64; i++) bset[i] = longint'($urandom_range(0, int'(QA) - 1));
    sb.delete();
    a_out_ready = 1'b1;
    for (int c = 0; c < n_ops + 50 && rcv < n_ops; c++) begin
      if (idx < n_ops) begin
        a_in_valid = 1'b1;
        a_in_a = longint'(idx >> 1);
        a_in_b = bset[idx & 63];
        a_in_tag = 8'(idx);
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (a_out_valid && a_out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++; $display("FAIL sweep_spurious: got tag %0h want none", a_out_tag);
        end else begin
          e = sb.pop_front();
          tests++; if (a_out_data !== e.data || a_out_tag !== e.tag) begin
            fails++; $display("FAIL sweep_result: got %0d/%0h want %0d/%0h", a_out_data, a_out_tag, e.data, e.tag);
          end
        end
        tests++; if (a_out_data >= QA) begin fails++; $display("FAIL sweep_range: got %0d want < %0d", a_out_data, QA); end
        rcv++;
      end
      if (a_in_valid && a_in_ready) begin
        e.data = (a_in_a * a_in_b) % QA;
        e.tag  = a_in_tag;
        sb.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    tests++; if (rcv != n_ops) begin fails++; $display("FAIL sweep_count: got %0d want %0d", rcv, n_ops); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int rcv = 0;
    logic hold_prev = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic [TW-1:0] prev_t = '0;
    exp_t e;
    sb.delete();
    for (int c = 0; c < 40; c++) begin
      a_out_ready = !(c >= 6 && c < 9);
      if (idx < 8) begin
        a_in_valid = 1'b1;
        a_in_a = longint'(100 * idx + 3);
        a_in_b = longint'(7000 - 50 * idx);
        a_in_tag = 8'h40 + 8'(idx);
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (hold_prev) begin
        tests++; if (a_out_data !== prev_d || a_out_tag !== prev_t) begin
          fails++; $display("FAIL bp_hold: got %0d/%0h want %0d/%0h", a_out_data, a_out_tag, prev_d, prev_t);
        end
      end
      if (a_out_valid && !a_out_ready) begin
        tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", a_in_ready); end
      end
      hold_prev = a_out_valid && !a_out_ready;
      prev_d = a_out_data;
      prev_t = a_out_tag;
      if (a_out_valid && a_out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++; $display("FAIL bp_spurious: got tag %0h want none", a_out_tag);
        end else begin
          e = sb.pop_front();
          tests++; if (a_out_data !== e.data || a_out_tag !== e.tag) begin
            fails++; $display("FAIL bp_result: got %0d/%0h want %0d/%0h", a_out_data, a_out_tag, e.data, e.tag);
          end
        end
        rcv++;
      end
      if (a_in_valid && a_in_ready) begin
        e.data = (a_in_a * a_in_b) % QA;
        e.tag  = a_in_tag;
        sb.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tests++; if (rcv != 8) begin fails++; $display("FAIL bp_count: got %0d want 8", rcv); end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL bp_leftover: got %0d want 0", sb.size()); end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_a = 64'd7000 - 64'(i); a_in_b = 64'd300; a_in_tag = 8'h60 + 8'(i);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_tag !== '0) begin
      fails++; $display("FAIL mrst_outputs: got %b/%0d/%0h want 0/0/0", a_out_valid, a_out_data, a_out_tag);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++; if (a_out_valid !== 1'b0 || a_out_data !== '0) begin
      fails++; $display("FAIL mrst_held: got %b/%0d want 0/0", a_out_valid, a_out_data);
    end
    rst_n = 1'b1;
    #1;
    a_in_valid = 1'b1; a_in_a = 64'd55; a_in_b = 64'd66; a_in_tag = 8'h77;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (a_out_valid) begin
        seen++;
        tests++; if (a_out_tag !== 8'h77 || a_out_data !== 64'd3630) begin
          fails++; $display("FAIL mrst_result: got %0d/%0h want 3630/77", a_out_data, a_out_tag);
        end
      end
    end
    tests++; if (seen != 1) begin fails++; $display("FAIL mrst_count: got %0d want 1", seen); end
  endtask

  task automatic test_variant();
    longint unsigned ca[4] = '{12288, 100, 0, 1};
    longint unsigned cb[4] = '{12288, 200, 5, 12288};
    longint unsigned ce[4] = '{1, 7711, 0, 12288};
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1; b_in_a = ca[i]; b_in_b = cb[i]; b_in_tag = 8'h90 + 8'(i);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (j < 4) begin
        tests++; if (b_out_valid !== 1'b1) begin fails++; $display("FAIL q2_valid%0d: got %b want 1", j, b_out_valid); end
        tests++; if (b_out_data !== ce[j]) begin fails++; $display("FAIL q2_data%0d: got %0d want %0d", j, b_out_data, ce[j]); end
        tests++; if (b_out_tag !== 8'h90 + 8'(j)) begin fails++; $display("FAIL q2_tag%0d: got %0h want %0h", j, b_out_tag, 8'h90 + 8'(j)); end
      end else begin
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL q2_tail%0d: got %b want 0", j, b_out_valid); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    a_in_valid = 1'b0; a_in_a = '0; a_in_b = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_in_tag = '0; b_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_mid_reset();
    test_variant();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
